// File: rtl/mac_threshold_unit_if.sv
// Signal bundle for the MAC/threshold unit: operands and threshold in,
// accumulator plus observation taps out.
interface mac_threshold_unit_if;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] threshold;
  logic [15:0] a;
  logic [15:0] prod;
  logic [15:0] sum;
  logic        co;
  logic        keep;

  modport master (
    output x, y, threshold,
    input  a, prod, sum, co, keep
  );

  modport slave (
    input  x, y, threshold,
    output a, prod, sum, co, keep
  );
endinterface

// File: rtl/mac_threshold_unit.sv
// Unsigned 8x8 multiply-accumulate core that clears its 16-bit accumulator
// whenever the running sum overflows or rises above a programmable threshold.
module mac_threshold_unit (
  input logic                  CLK,
  input logic                  RESET,
  mac_threshold_unit_if.slave  bus
);

  logic [15:0] r_a;
  logic [15:0] w_prod;
  logic [15:0] w_sum;
  logic        w_co;
  logic        w_keep;
  logic        w_carry;
  logic [1:0]  w_fa;

  // Returns {carry, sum} of a single-bit full adder.
  function automatic logic [1:0] fullAdd(input logic aIn, input logic bIn, input logic cIn);
    return {(aIn & bIn) | (aIn & cIn) | (bIn & cIn), aIn ^ bIn ^ cIn};
  endfunction

  // Shift-and-add partial products; the 16-bit result cannot overflow for 8x8.
  always_comb begin
    w_prod = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      w_prod = w_prod + (bus.y[i] ? ({8'h00, bus.x} << i) : 16'h0000);
    end
  end

  always_comb begin
    w_carry = 1'b0;
    w_fa    = 2'b00;
    w_sum   = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      w_fa     = fullAdd(r_a[i], w_prod[i], w_carry);
      w_sum[i] = w_fa[0];
      w_carry  = w_fa[1];
    end
    w_co = w_carry;
  end

  assign w_keep = (w_sum <= bus.threshold);

  // Overflow takes precedence: a carry-out clears even at the maximum threshold.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_a <= 16'h0000;
    end else if (w_co || !w_keep) begin
      r_a <= 16'h0000;
    end else begin
      r_a <= w_sum;
    end
  end

  assign bus.a    = r_a;
  assign bus.prod = w_prod;
  assign bus.sum  = w_sum;
  assign bus.co   = w_co;
  assign bus.keep = w_keep;

endmodule

// File: tb/tb_mac_threshold_unit.sv
// Directed self-checking bench for mac_threshold_unit: accumulate/clear,
// equality, overflow, idle operands, async reset and a full multiplier sweep.
`timescale 1ns/1ps
module tb_mac_threshold_unit;

  logic CLK;
  logic RESET;
  int   assertCount;
  int   failCount;

  mac_threshold_unit_if bus ();

  mac_threshold_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, simulation stuck");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] th);
    bus.x         = xv;
    bus.y         = yv;
    bus.threshold = th;
  endtask

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseReset();
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    applyStimulus(8'd0, 8'd0, 16'd0);
    RESET = 1'b0;
    #1;
    assertCount++;
    if (bus.a !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL reset_a: got %h expected 0000", bus.a);
    end
    assertCount++;
    if (bus.keep !== 1'b1 || bus.co !== 1'b0 || bus.sum !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL reset_comb: got keep=%b co=%b sum=%h expected 1 0 0000", bus.keep, bus.co, bus.sum);
    end
    stepClock();
    assertCount++;
    if (bus.a !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL reset_hold: got %h expected 0000", bus.a);
    end
  endtask

  task automatic test_basic();
    logic [15:0] expected [10];
    expected = '{16'd12, 16'd24, 16'd36, 16'd48, 16'd60, 16'd72, 16'd84, 16'd96, 16'd0, 16'd12};
    applyStimulus(8'd3, 8'd4, 16'd100);
    RESET = 1'b1;
    #1;
    assertCount++;
    if (bus.prod !== 16'd12 || bus.sum !== 16'd12) begin
      failCount++;
      $display("[TB] FAIL basic_comb: got prod=%0d sum=%0d expected 12 12", bus.prod, bus.sum);
    end
    for (int i = 0; i < 10; i++) begin
      stepClock();
      assertCount++;
      if (bus.a !== expected[i]) begin
        failCount++;
        $display("[TB] FAIL basic_step%0d: got %0d expected %0d", i, bus.a, expected[i]);
      end
    end
  endtask

  task automatic test_equality();
    logic [15:0] expected [6];
    expected = '{16'd12, 16'd24, 16'd0, 16'd12, 16'd24, 16'd0};
    pulseReset();
    applyStimulus(8'd3, 8'd4, 16'd24);
    for (int i = 0; i < 6; i++) begin
      stepClock();
      assertCount++;
      if (bus.a !== expected[i]) begin
        failCount++;
        $display("[TB] FAIL equality_step%0d: got %0d expected %0d", i, bus.a, expected[i]);
      end
    end
  endtask

  task automatic test_overflow();
    pulseReset();
    applyStimulus(8'd255, 8'd255, 16'hFFFF);
    #1;
    assertCount++;
    if (bus.prod !== 16'hFE01) begin
      failCount++;
      $display("[TB] FAIL overflow_prod: got %h expected fe01", bus.prod);
    end
    stepClock();
    assertCount++;
    if (bus.a !== 16'hFE01) begin
      failCount++;
      $display("[TB] FAIL overflow_first: got %h expected fe01", bus.a);
    end
    assertCount++;
    if (bus.sum !== 16'hFC02 || bus.co !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL overflow_carry: got sum=%h co=%b expected fc02 1", bus.sum, bus.co);
    end
    stepClock();
    assertCount++;
    if (bus.a !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL overflow_clear: got %h expected 0000", bus.a);
    end
    stepClock();
    assertCount++;
    if (bus.a !== 16'hFE01) begin
      failCount++;
      $display("[TB] FAIL overflow_again: got %h expected fe01", bus.a);
    end
  endtask

  task automatic test_zero_operand();
    pulseReset();
    applyStimulus(8'd3, 8'd4, 16'd100);
    stepClock();
    stepClock();
    assertCount++;
    if (bus.a !== 16'd24) begin
      failCount++;
      $display("[TB] FAIL zero_setup: got %0d expected 24", bus.a);
    end
    applyStimulus(8'd0, 8'd4, 16'd100);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      assertCount++;
      if (bus.a !== 16'd24 || bus.prod !== 16'd0) begin
        failCount++;
        $display("[TB] FAIL zero_hold%0d: got a=%0d prod=%0d expected 24 0", i, bus.a, bus.prod);
      end
    end
    applyStimulus(8'd0, 8'd4, 16'd10);
    #1;
    assertCount++;
    if (bus.keep !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL zero_keep_low: got %b expected 0", bus.keep);
    end
    stepClock();
    assertCount++;
    if (bus.a !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL zero_threshold_drop: got %0d expected 0", bus.a);
    end
    applyStimulus(8'd1, 8'd1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      assertCount++;
      if (bus.a !== 16'd0) begin
        failCount++;
        $display("[TB] FAIL zero_threshold_zero%0d: got %0d expected 0", i, bus.a);
      end
    end
  endtask

  task automatic test_async_reset();
    pulseReset();
    applyStimulus(8'd3, 8'd4, 16'd100);
    for (int i = 0; i < 4; i++) stepClock();
    assertCount++;
    if (bus.a !== 16'd48) begin
      failCount++;
      $display("[TB] FAIL async_setup: got %0d expected 48", bus.a);
    end
    #2;
    RESET = 1'b0;
    #1;
    assertCount++;
    if (bus.a !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL async_clear: got %0d expected 0", bus.a);
    end
    #1;
    RESET = 1'b1;
    stepClock();
    assertCount++;
    if (bus.a !== 16'd12) begin
      failCount++;
      $display("[TB] FAIL async_restart: got %0d expected 12", bus.a);
    end
  endtask

  task automatic test_mult_sweep();
    logic [15:0] expProd;
    logic        expKeep;
    RESET = 1'b0;
    bus.threshold = 16'h8000;
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 256; yi++) begin
        bus.x   = xi[7:0];
        bus.y   = yi[7:0];
        expProd = 16'(xi * yi);
        expKeep = (expProd <= 16'h8000);
        #1;
        assertCount++;
        if (bus.prod !== expProd || bus.sum !== expProd) begin
          failCount++;
          $display("[TB] FAIL sweep_prod x=%0d y=%0d: got prod=%h sum=%h expected %h", xi, yi, bus.prod, bus.sum, expProd);
        end
        assertCount++;
        if (bus.co !== 1'b0 || bus.keep !== expKeep) begin
          failCount++;
          $display("[TB] FAIL sweep_flags x=%0d y=%0d: got co=%b keep=%b expected 0 %b", xi, yi, bus.co, bus.keep, expKeep);
        end
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    RESET       = 1'b0;
    applyStimulus(8'd0, 8'd0, 16'd0);
    @(posedge CLK);
    #1;
    test_reset();
    test_basic();
    test_equality();
    test_overflow();
    test_zero_operand();
    test_async_reset();
    test_mult_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
